ldpc_parity_receiver: RTL
=========================

# ldpc_parity_receiver

Downstream sink for the LDPC encoder's serial parity output. It accepts the encoder's one-bit valid/ready stream and packs bits MSB-first into bytes. Bytes are buffered in a small FIFO and emitted on a byte stream with start/end-of-frame markers. Once the last byte of a frame has been delivered, the block pulses `dec_complete` back to the encoder, closing the encoder's frame handshake.

## Interface
- `FIFO_DEPTH`, 16, byte FIFO entries; power of two, ≥ 2.
- `clk`  in  1  sole clock; all logic on rising edge.
- `arst_n`  in  1  reset, asynchronous assert, active-low.
- `frame_start`  in  1  one-cycle pulse that arms reception of one frame.
- `cfg_q`  in  8  encoder q constant; sampled only when `frame_start` is accepted.
- `enc_bits`  in  1  serial parity bit from the encoder.
- `enc_valid`  in  1  `enc_bits` valid.
- `enc_ready`  out  1  block accepts a bit this cycle.
- `dec_complete`  out  1  one-cycle pulse after the frame has fully drained; drives the encoder's `dst_dec_complete`.
- `out_byte`  out  8  packed byte; the first received bit is bit 7.
- `out_valid`  out  1  `out_byte` valid.
- `out_ready`  in  1  consumer accepts the byte.
- `out_start_frame`  out  1  qualifies the first byte of a frame; valid with `out_valid`.
- `out_end_frame`  out  1  qualifies the last byte of a frame; valid with `out_valid`.
- `err`  out  1  one-cycle error pulse.

## Operation
- Frame length:
  - Bits per frame = 360·(q−1). Bytes per frame = 45·(q−1).
  - A 13-bit byte target is computed as 45·(`cfg_q`−1) and registered at `frame_start`. Maximum is 45·181 = 8145 for q=182.
  - q ≥ 2 is required.
- States: IDLE, RECV, DRAIN, DONE.
  - IDLE: `frame_start`=1 with `cfg_q` ≥ 2 → RECV. Latch the target, clear the bit counter (3b), byte counter (13b) and shift register.
  - IDLE: `frame_start`=1 with `cfg_q` < 2 → `err` pulse next cycle; stay in IDLE.
  - RECV: `enc_ready` = !fifo_full. A bit handshake (`enc_valid` && `enc_ready`) shifts `enc_bits` into the LSB and increments the bit counter.
  - RECV, 8th bit: the completed byte is pushed into the FIFO in the same cycle with flags start = (byte_cnt==0) and end = (byte_cnt==target−1). The byte counter increments.
  - RECV: push of the end byte → DRAIN.
  - DRAIN: `enc_ready`=0. Wait for the handshake of the byte with end flag set → DONE.
  - DONE: `dec_complete`=1 for exactly one cycle → IDLE.
- FIFO:
  - 10-bit entries {start, end, byte}.
  - Show-ahead: `out_*` reflect the head entry. `out_valid` = !empty.
  - Push and pop in the same cycle are both performed, including when full. Pointers wrap modulo `FIFO_DEPTH`.
  - Never push when full; the `enc_ready` gating guarantees this.
- `frame_start` while not in IDLE: ignored, and `err` pulses for one cycle. The current frame is unaffected.
- `enc_valid` in IDLE/DRAIN/DONE: no handshake, since `enc_ready`=0. Bits are held by the encoder.
- Simultaneous events:
  - Final byte push and pop of an older byte in the same cycle: both proceed.
  - `frame_start` during DONE: ignored with `err`.

## Timing
- Reset (async, `arst_n`=0) sets:
  - state=IDLE;
  - `enc_ready`=0, `out_valid`=0, `out_byte`=0, `out_start_frame`=0, `out_end_frame`=0;
  - `dec_complete`=0, `err`=0;
  - FIFO empty, all counters 0.
- Reset mid-frame discards all partial state and buffered bytes. No `dec_complete` is issued.
- `enc_ready` is registered-state driven: it rises the cycle after `frame_start` is accepted.
- Latency: 8th bit handshake at cycle N → `out_valid`=1 with that byte at cycle N+1, provided the FIFO was empty.
- Throughput: 1 bit/cycle in sustained while `out_ready`=1. Output runs ≤ 1 byte per 8 cycles.
- `dec_complete` is asserted exactly at cycle M+1, where M is the `out_end_frame` byte handshake cycle.
- A new `frame_start` is accepted at cycle M+2 at the earliest.
- `err` is registered: asserted at cycle E+1 after the offending input cycle E, for one cycle.

## Test plan
- **Basic frame:** `cfg_q`=2, bit stream = repeating 8'hA5 pattern MSB-first, `out_ready`=1. Required:
  - exactly 45 bytes, all 8'hA5;
  - `out_start_frame` only on byte 0, `out_end_frame` only on byte 44;
  - `dec_complete` one cycle after byte 44, `enc_ready` low after bit 360.
- **Backpressure:** `cfg_q`=3, `out_ready`=0. Required: `enc_ready` drops after exactly 128 bits (16 bytes). Releasing `out_ready` resumes; all 90 bytes arrive in order.
- **Invalid config:** `frame_start` with `cfg_q`=1 or 0. Required: `err` pulse, state stays IDLE, `enc_ready` stays 0.
- **Mid-frame restart:** `frame_start` at bit 100 of a q=2 frame. Required: `err` pulse; the frame still completes with 45 bytes and one `dec_complete`.
- **Reset mid-frame:** drop `arst_n` after 20 bytes. Required:
  - all outputs are 0 immediately;
  - no `dec_complete`;
  - the next q=2 frame yields 45 bytes with `out_start_frame` on its first byte.
- **Large frame with random `out_ready` and `enc_valid` gaps:** `cfg_q`=135. Required: 6030 bytes matching the packed reference bit file, and a single `dec_complete`.

Source files
------------

// File: rtl/ldpc_parity_receiver.sv
// Serial-bit sink for the LDPC encoder parity stream: packs bits MSB-first into bytes,
// buffers them in a show-ahead FIFO with frame markers and signals frame completion.
module ldpc_parity_receiver #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       frame_start,
  input  logic [7:0] cfg_q,
  input  logic       enc_bits,
  input  logic       enc_valid,
  output logic       enc_ready,
  output logic       dec_complete,
  output logic [7:0] out_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_start_frame,
  output logic       out_end_frame,
  output logic       err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_t;

  state_t      state;
  logic [12:0] target;
  logic [12:0] byte_cnt;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift;
  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  logic        empty;
  logic        full;
  logic        bit_hs;
  logic        push;
  logic        pop;
  logic        is_last;
  logic [9:0]  head;
  logic [9:0]  push_entry;
  logic [12:0] target_calc;

  // Extra pointer MSB distinguishes full from empty when the indices coincide.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign enc_ready   = (state == RECV) && !full;
  assign bit_hs      = enc_valid && enc_ready;
  assign push        = bit_hs && (bit_cnt == 3'd7);
  assign is_last     = (byte_cnt == target - 13'd1);
  assign push_entry  = {(byte_cnt == 13'd0), is_last, shift, enc_bits};
  assign target_calc = 13'(cfg_q - 8'd1) * 13'd45;

  assign head            = mem[rd_ptr[AW-1:0]];
  assign out_valid       = !empty;
  assign out_byte        = empty ? 8'd0 : head[7:0];
  assign out_start_frame = !empty && head[9];
  assign out_end_frame   = !empty && head[8];
  assign pop             = out_valid && out_ready;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state        <= IDLE;
      target       <= '0;
      byte_cnt     <= '0;
      bit_cnt      <= '0;
      err          <= 1'b0;
      dec_complete <= 1'b0;
    end else begin
      err          <= 1'b0;
      dec_complete <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            if (cfg_q >= 8'd2) begin
              state    <= RECV;
              target   <= target_calc;
              bit_cnt  <= '0;
              byte_cnt <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        RECV: begin
          if (frame_start) err <= 1'b1;
          if (bit_hs) bit_cnt <= bit_cnt + 3'd1;
          if (push) begin
            byte_cnt <= byte_cnt + 13'd1;
            if (is_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (frame_start) err <= 1'b1;
          if (pop && head[8]) begin
            state        <= DONE;
            dec_complete <= 1'b1;
          end
        end
        default: begin
          if (frame_start) err <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  // Partial byte accumulates here; the eighth bit bypasses it straight into the FIFO.
  always_ff @(posedge clk) begin
    if (state == IDLE && frame_start) shift <= '0;
    else if (bit_hs)                  shift <= {shift[5:0], enc_bits};
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule
